round_controller: RTL and testbench

Game-round sequencer that owns the lives counter and the target light.
- Loads the configured life count into the lives counter and paces gap/target windows.
- Scores hits and issues miss pulses when a target window times out.
- Parks in a game-over state when the lives counter reports zero lives.
- Sits between the top-level button/switch inputs and the lives counter, score display and target LED.

---
 rtl/round_controller.sv | 146 ++++++++++++++
 tb/tb_round_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// Game-round sequencer: loads the lives counter, paces gap/target windows,
// scores hits, issues miss pulses on timeout and parks when lives run out.
module round_controller #(
    parameter int GAP_CYCLES     = 25_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int MISS_HOLD      = 2,
    parameter int SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         lives_cfg,
    input  logic               hit,
    input  logic [3:0]         lives,
    input  logic               game_over,
    output logic               lives_set,
    output logic [3:0]         lives_inp,
    output logic               lives_rst,
    output logic               miss_out,
    output logic               target_on,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state_dbg
);

    localparam int MAX_GT  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_GT > MISS_HOLD) ? MAX_GT : MISS_HOLD;
    localparam int TMR_W   = $clog2(MAX_CYC);

    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] MISS_LAST = TMR_W'(MISS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GAP   = 3'd2,
        ARM   = 3'd3,
        MISS  = 3'd4,
        CHECK = 3'd5,
        OVER  = 3'd6
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             start_q;
    logic             hit_q;
    logic             start_rise;
    logic             hit_rise;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (&s) ? s : s + 1'b1;
    endfunction

    // A zero life count would end the game before it starts, so it loads as one.
    function automatic logic [3:0] lives_load(input logic [3:0] cfg);
        return (cfg == 4'd0) ? 4'd1 : cfg;
    endfunction

    assign start_rise = start & ~start_q;
    assign hit_rise   = hit & ~hit_q;
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            start_q   <= 1'b1;
            hit_q     <= 1'b1;
            lives_set <= 1'b0;
            lives_inp <= 4'd0;
            lives_rst <= 1'b1;
            miss_out  <= 1'b0;
            target_on <= 1'b0;
            score     <= '0;
        end else begin
            start_q   <= start;
            hit_q     <= hit;
            lives_set <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        state     <= LOAD;
                        lives_set <= 1'b1;
                        lives_inp <= lives_load(lives_cfg);
                        lives_rst <= 1'b0;
                        score     <= '0;
                    end
                end
                LOAD: begin
                    state <= GAP;
                    timer <= '0;
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        state     <= ARM;
                        target_on <= 1'b1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ARM: begin
                    // A hit on the final window cycle still beats the timeout.
                    if (hit_rise) begin
                        score     <= sat_inc(score);
                        state     <= GAP;
                        target_on <= 1'b0;
                        timer     <= '0;
                    end else if (timer == TMO_LAST) begin
                        state     <= MISS;
                        target_on <= 1'b0;
                        miss_out  <= 1'b1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                MISS: begin
                    if (timer == MISS_LAST) begin
                        state    <= CHECK;
                        miss_out <= 1'b0;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    timer <= '0;
                    if (lives == 4'd0 || game_over) begin
                        state <= OVER;
                    end else begin
                        state <= GAP;
                    end
                end
                default: begin
                    state     <= IDLE;
                    lives_rst <= 1'b1;
                    miss_out  <= 1'b0;
                    target_on <= 1'b0;
                    timer     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Randomized scoreboard bench for round_controller with a behavioural lives counter.
module tb_round_controller;

    localparam int G  = 4;
    localparam int T  = 8;
    localparam int M  = 2;
    localparam int SW = 4;

    localparam int EV_LOAD  = 1;
    localparam int EV_SCORE = 2;
    localparam int EV_TGT   = 3;
    localparam int EV_MISS  = 4;
    localparam int EV_OVER  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          hit = 1'b0;
    logic [3:0]    lives_cfg = 4'd0;
    logic [3:0]    lives_m;
    logic          game_over;
    logic          lives_set;
    logic [3:0]    lives_inp;
    logic          lives_rst;
    logic          miss_out;
    logic          target_on;
    logic [SW-1:0] score;
    logic [2:0]    state_dbg;
    logic          miss_q;

    round_controller #(
        .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .MISS_HOLD(M), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .lives_cfg(lives_cfg), .hit(hit),
        .lives(lives_m), .game_over(game_over), .lives_set(lives_set),
        .lives_inp(lives_inp), .lives_rst(lives_rst), .miss_out(miss_out),
        .target_on(target_on), .score(score), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Lives counter: decrements once per miss pulse, flags game over at zero.
    always @(posedge clk) begin
        miss_q <= miss_out;
        if (lives_rst) lives_m <= 4'd0;
        else if (lives_set) lives_m <= lives_inp;
        else if (miss_out && !miss_q && lives_m != 4'd0) lives_m <= lives_m - 4'd1;
    end
    assign game_over = (lives_m == 4'd0);

    typedef struct {int kind; int val; int cyc;} ev_t;
    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  score_m = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic push_ev(input int k, input int v, input int c);
        ev_t e;
        e.kind = k; e.val = v; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic seen(input int k, input int v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event at cycle %0d: got kind %0d val %0d, expected none", cyc, k, v);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            check("event_value", v, e.val);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    int prev_target = 0, prev_score = 0, prev_state = 0, miss_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_target = 0; prev_score = 0; prev_state = 0; miss_len = 0;
        end else begin
            if (lives_set) seen(EV_LOAD, int'(lives_inp));
            if (int'(score) != prev_score) seen(EV_SCORE, int'(score));
            if (target_on && prev_target == 0) seen(EV_TGT, 0);
            if (miss_out) miss_len++;
            else if (miss_len > 0) begin
                seen(EV_MISS, miss_len);
                miss_len = 0;
            end
            if (state_dbg == 3'd6 && prev_state != 6) seen(EV_OVER, 0);
            prev_target = int'(target_on);
            prev_score  = int'(score);
            prev_state  = int'(state_dbg);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic start_game(input int cfg, output int k);
        int eff;
        step();
        lives_cfg = cfg[3:0];
        start = 1'b1;
        k = cyc;
        eff = (cfg == 0) ? 1 : cfg;
        push_ev(EV_LOAD, eff, k + 1);
        if (score_m != 0) push_ev(EV_SCORE, 0, k + 1);
        score_m = 0;
        step();
        start = 1'b0;
        lives_cfg = 4'($urandom_range(0, 15));
    endtask

    // pol: 0 random, 1 always miss, 2 twenty hits then misses,
    //      3 held hit then timeout-cycle hit then misses, 4 reset in first miss
    task automatic play_game(input int cfg, input int pol);
        int k, arm0, lives_e, r, act, j, v, old;
        bit done, spur;
        start_game(cfg, k);
        lives_e = (cfg == 0) ? 1 : cfg;
        arm0 = k + 2 + G;
        push_ev(EV_TGT, 0, arm0);
        r = 0;
        done = 1'b0;
        while (!done) begin
            j = 3;
            spur = 1'b0;
            case (pol)
                0: begin
                    v = $urandom_range(0, 9);
                    act = (r >= 25) ? 1 : (v < 6) ? 0 : (v < 8) ? 1 : 2;
                    j = $urandom_range(1, T);
                    spur = ($urandom_range(0, 1) == 1);
                end
                1: act = 1;
                2: act = (r < 20) ? 0 : 1;
                3: begin
                    act = (r == 0) ? 2 : (r == 1) ? 0 : 1;
                    j = T;
                end
                default: act = 3;
            endcase
            wait_until(arm0 - 3);
            if (spur && act != 2) begin
                hit = 1'b1;
                start = ($urandom_range(0, 1) == 1);
                step();
                hit = 1'b0;
                start = 1'b0;
            end
            if (act == 2) begin
                wait_until(arm0 - 2);
                hit = 1'b1;
            end
            if (act == 0) begin
                old = score_m;
                score_m = (score_m == 15) ? 15 : score_m + 1;
                if (score_m != old) push_ev(EV_SCORE, score_m, arm0 + j);
                wait_until(arm0 + j - 1);
                hit = 1'b1;
                step();
                hit = 1'b0;
                arm0 = arm0 + j + G;
                push_ev(EV_TGT, 0, arm0);
            end else if (act == 3) begin
                wait_until(arm0 + T);
                check("miss_out_first_cycle", int'(miss_out), 1);
                rst = 1'b1;
                step();
                check("rst_mid_miss_state", int'(state_dbg), 0);
                check("rst_mid_miss_miss_out", int'(miss_out), 0);
                check("rst_mid_miss_lives_rst", int'(lives_rst), 1);
                check("rst_mid_miss_score", int'(score), 0);
                rst = 1'b0;
                score_m = 0;
                done = 1'b1;
            end else begin
                push_ev(EV_MISS, M, arm0 + T + M);
                lives_e--;
                if (lives_e == 0) begin
                    push_ev(EV_OVER, 0, arm0 + T + M + 1);
                    done = 1'b1;
                end else begin
                    push_ev(EV_TGT, 0, arm0 + T + M + 1 + G);
                end
                if (act == 2) begin
                    wait_until(arm0 + 2);
                    hit = 1'b0;
                end
                wait_until(arm0 + T + M + 1);
                check("lives_after_miss", int'(lives_m), lives_e);
                if (done) begin
                    repeat (2) step();
                    check("over_state", int'(state_dbg), 6);
                    check("over_target_off", int'(target_on), 0);
                    check("over_score_frozen", int'(score), score_m);
                end
                arm0 = arm0 + T + M + 1 + G;
            end
            r++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        lives_cfg = 4'd3;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        check("reset_state", int'(state_dbg), 0);
        check("reset_lives_rst", int'(lives_rst), 1);
        check("reset_lives_set", int'(lives_set), 0);
        check("reset_lives_inp", int'(lives_inp), 0);
        check("reset_miss_out", int'(miss_out), 0);
        check("reset_target_on", int'(target_on), 0);
        check("reset_score", int'(score), 0);
        start = 1'b0;
        repeat (2) step();

        play_game(3, 1);
        play_game(0, 1);
        play_game(2, 2);
        check("saturated_score", int'(score), 15);
        play_game(2, 3);
        play_game(3, 4);
        repeat (3) step();
        repeat (6) play_game($urandom_range(0, 4), 0);

        repeat (10) step();
        check("events_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
